// File: rtl/laser_rx_buffer.sv
// Show-ahead FIFO behind LaserReceiver: captures {data1_in, data2_in} on each
// data_valid rising edge and reports drops/empty reads with sticky flags.
module laser_rx_buffer #(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             data_valid,
    input  logic [7:0]       data1_in,
    input  logic [7:0]       data2_in,
    input  logic             rd_en,
    input  logic             clear_flags,
    output logic [15:0]      rd_data,
    output logic             rd_valid,
    output logic             full,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             underflow,
    output logic [7:0]       drop_cnt
);

    localparam int               AW      = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ZERO_C  = CNT_W'(0);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [AW-1:0]    PTR_ONE = AW'(1);
    localparam logic [7:0]       DROP_MAX = 8'hFF;

    logic [15:0]      mem_r [DEPTH];
    logic             dv_q_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             full_r;
    logic             rd_valid_r;
    logic [15:0]      rd_data_r;
    logic             overflow_r;
    logic             underflow_r;
    logic [7:0]       drop_cnt_r;

    logic             push_s;
    logic             pop_s;
    logic             wr_en_s;
    logic             drop_s;
    logic             uflow_s;
    logic [15:0]      din_s;
    logic [AW-1:0]    wr_ptr_nxt_s;
    logic [AW-1:0]    rd_ptr_nxt_s;
    logic [CNT_W-1:0] count_nxt_s;
    logic [15:0]      head_nxt_s;
    logic             overflow_nxt_s;
    logic             underflow_nxt_s;
    logic [7:0]       drop_cnt_nxt_s;

    // Push/pop qualification: a full FIFO still accepts a push when a pop frees a slot.
    always_comb begin
        push_s  = data_valid & ~dv_q_r;
        pop_s   = rd_en & rd_valid_r;
        wr_en_s = push_s & (~full_r | pop_s);
        drop_s  = push_s & full_r & ~pop_s;
        uflow_s = rd_en & ~rd_valid_r;
        din_s   = {data1_in, data2_in};
    end

    // Pointer and fill-level next state.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        if (wr_en_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        case ({wr_en_s, pop_s})
            2'b10:   count_nxt_s = count_r + ONE_C;
            2'b01:   count_nxt_s = count_r - ONE_C;
            default: count_nxt_s = count_r;
        endcase
    end

    // Next head entry; bypass the write data when the new head is written this cycle.
    always_comb begin
        head_nxt_s = 16'h0000;
        if (count_nxt_s == ZERO_C) begin
            head_nxt_s = 16'h0000;
        end else if (wr_en_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = din_s;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Sticky status next state; a new event in the clear cycle wins over the clear.
    always_comb begin
        overflow_nxt_s  = overflow_r;
        underflow_nxt_s = underflow_r;
        drop_cnt_nxt_s  = drop_cnt_r;
        if (drop_s) begin
            overflow_nxt_s = 1'b1;
        end else if (clear_flags) begin
            overflow_nxt_s = 1'b0;
        end else begin
            overflow_nxt_s = overflow_r;
        end
        if (uflow_s) begin
            underflow_nxt_s = 1'b1;
        end else if (clear_flags) begin
            underflow_nxt_s = 1'b0;
        end else begin
            underflow_nxt_s = underflow_r;
        end
        if (drop_s) begin
            if (clear_flags) begin
                drop_cnt_nxt_s = 8'd1;
            end else if (drop_cnt_r == DROP_MAX) begin
                drop_cnt_nxt_s = DROP_MAX;
            end else begin
                drop_cnt_nxt_s = drop_cnt_r + 8'd1;
            end
        end else if (clear_flags) begin
            drop_cnt_nxt_s = 8'd0;
        end else begin
            drop_cnt_nxt_s = drop_cnt_r;
        end
    end

    // Storage array; contents are intentionally left unreset.
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= din_s;
        end
    end

    // Control and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dv_q_r      <= 1'b0;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= ZERO_C;
            full_r      <= 1'b0;
            rd_valid_r  <= 1'b0;
            rd_data_r   <= 16'h0000;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
            drop_cnt_r  <= 8'd0;
        end else begin
            dv_q_r      <= data_valid;
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            count_r     <= count_nxt_s;
            full_r      <= (count_nxt_s == DEPTH_C);
            rd_valid_r  <= (count_nxt_s != ZERO_C);
            rd_data_r   <= head_nxt_s;
            overflow_r  <= overflow_nxt_s;
            underflow_r <= underflow_nxt_s;
            drop_cnt_r  <= drop_cnt_nxt_s;
        end
    end

    assign rd_data   = rd_data_r;
    assign rd_valid  = rd_valid_r;
    assign full      = full_r;
    assign count     = count_r;
    assign overflow  = overflow_r;
    assign underflow = underflow_r;
    assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_laser_rx_buffer.sv
// Self-checking bench for laser_rx_buffer: vector table for the single-push case,
// plus a queue-based reference model for fill, overflow, wrap and reset sequences.
module tb_laser_rx_buffer;

    localparam int DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        data_valid;
    logic [7:0]  data1_in;
    logic [7:0]  data2_in;
    logic        rd_en;
    logic        clear_flags;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        full;
    logic [4:0]  count;
    logic        overflow;
    logic        underflow;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] m_q[$];
    logic        m_dvq;
    logic        m_ovf;
    logic        m_udf;
    int          m_drop;

    typedef struct {
        logic        dv;
        logic [7:0]  d1;
        logic [7:0]  d2;
        logic        rd;
        logic        clr;
        logic [4:0]  e_count;
        logic        e_valid;
        logic        e_full;
        logic [15:0] e_data;
        logic        e_ovf;
        logic        e_udf;
        logic [7:0]  e_drop;
    } vec_t;

    vec_t vecs[8];

    laser_rx_buffer dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .data_valid  (data_valid),
        .data1_in    (data1_in),
        .data2_in    (data2_in),
        .rd_en       (rd_en),
        .clear_flags (clear_flags),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .full        (full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .drop_cnt    (drop_cnt)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_dvq  = 1'b0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        m_drop = 0;
    endtask

    task automatic check_model(input string tag);
        logic [15:0] head;
        head = (m_q.size() != 0) ? m_q[0] : 16'h0000;
        chk({tag, ".count"},     32'(count),     32'(m_q.size()));
        chk({tag, ".rd_valid"},  32'(rd_valid),  32'(m_q.size() != 0));
        chk({tag, ".full"},      32'(full),      32'(m_q.size() == DEPTH));
        chk({tag, ".rd_data"},   32'(rd_data),   32'(head));
        chk({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
        chk({tag, ".underflow"}, 32'(underflow), 32'(m_udf));
        chk({tag, ".drop_cnt"},  32'(drop_cnt),  32'(m_drop));
    endtask

    // Drive one cycle from posedge+1, advance the model, check after the edge.
    task automatic tick(input logic dv, input logic [7:0] d1, input logic [7:0] d2,
                        input logic rd, input logic clr);
        logic m_valid, m_full, m_push, m_pop, m_dropped;
        logic [15:0] popped;
        data_valid  = dv;
        data1_in    = d1;
        data2_in    = d2;
        rd_en       = rd;
        clear_flags = clr;
        #3;
        m_valid = (m_q.size() != 0);
        m_full  = (m_q.size() == DEPTH);
        m_push  = dv & ~m_dvq;
        m_pop   = rd & m_valid;
        m_dropped = m_push & m_full & ~m_pop;
        if (m_pop) begin
            popped = m_q.pop_front();
            chk("scoreboard_pop", 32'(rd_data), 32'(popped));
        end
        if (m_push && !m_dropped) m_q.push_back({d1, d2});
        if (m_dropped) begin
            m_ovf  = 1'b1;
            m_drop = clr ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
        end else if (clr) begin
            m_ovf  = 1'b0;
            m_drop = 0;
        end
        if (rd && !m_valid) m_udf = 1'b1;
        else if (clr) m_udf = 1'b0;
        m_dvq = dv;
        @(posedge clock);
        #1;
        check_model("model");
    endtask

    task automatic pulse(input logic [7:0] d1, input logic [7:0] d2);
        tick(1'b1, d1, d2, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 8'h12, 8'h34, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 8'd0};
        vecs[1] = '{1'b1, 8'h56, 8'h78, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 8'd0};
        vecs[2] = '{1'b1, 8'h9A, 8'hBC, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 8'd0};
        vecs[3] = '{1'b1, 8'h12, 8'h34, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 8'd0};
        vecs[4] = '{1'b1, 8'h12, 8'h34, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 8'd0};
        vecs[5] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'd0};
        vecs[6] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 8'd0};
        vecs[7] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'd0};

        // 1: reset with random inputs
        reset_n = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            data_valid  = 1'($urandom);
            data1_in    = 8'($urandom);
            data2_in    = 8'($urandom);
            rd_en       = 1'($urandom);
            clear_flags = 1'($urandom);
            @(posedge clock);
            #1;
            chk("reset.count",    32'(count),    32'd0);
            chk("reset.rd_valid", 32'(rd_valid), 32'd0);
            chk("reset.full",     32'(full),     32'd0);
            chk("reset.rd_data",  32'(rd_data),  32'h0);
            chk("reset.flags",    32'({overflow, underflow}), 32'd0);
            chk("reset.drop_cnt", 32'(drop_cnt), 32'd0);
        end
        data_valid = 1'b0; data1_in = 8'h00; data2_in = 8'h00;
        rd_en = 1'b0; clear_flags = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

        // 2: single push from a held level, pop, empty read, clear (vector table)
        for (int i = 0; i < 8; i++) begin
            tick(vecs[i].dv, vecs[i].d1, vecs[i].d2, vecs[i].rd, vecs[i].clr);
            chk($sformatf("vec%0d.count", i),     32'(count),     32'(vecs[i].e_count));
            chk($sformatf("vec%0d.rd_valid", i),  32'(rd_valid),  32'(vecs[i].e_valid));
            chk($sformatf("vec%0d.full", i),      32'(full),      32'(vecs[i].e_full));
            chk($sformatf("vec%0d.rd_data", i),   32'(rd_data),   32'(vecs[i].e_data));
            chk($sformatf("vec%0d.overflow", i),  32'(overflow),  32'(vecs[i].e_ovf));
            chk($sformatf("vec%0d.underflow", i), 32'(underflow), 32'(vecs[i].e_udf));
            chk($sformatf("vec%0d.drop_cnt", i),  32'(drop_cnt),  32'(vecs[i].e_drop));
        end

        // 3: fill, overflow by 3, ordered drain, clear
        for (int i = 0; i < 16; i++) pulse(8'h00, 8'(i));
        for (int i = 0; i < 3; i++) pulse(8'hEE, 8'(i));
        chk("fill.full",     32'(full),     32'd1);
        chk("fill.overflow", 32'(overflow), 32'd1);
        chk("fill.drop_cnt", 32'(drop_cnt), 32'd3);
        for (int i = 0; i < 16; i++) begin
            chk("drain.order", 32'(rd_data), 32'(i));
            tick(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        end
        chk("drain.empty", 32'(rd_valid), 32'd0);
        tick(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        chk("clear.overflow", 32'(overflow), 32'd0);
        chk("clear.drop_cnt", 32'(drop_cnt), 32'd0);

        // 4: push and pop together while full
        for (int i = 0; i < 16; i++) pulse(8'h40, 8'(i));
        tick(1'b1, 8'hAB, 8'hCD, 1'b1, 1'b0);
        chk("fullpp.count",    32'(count),    32'd16);
        chk("fullpp.overflow", 32'(overflow), 32'd0);
        tick(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("fullpp.last", 32'(rd_data), 32'hABCD);
            tick(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        end

        // drop counter saturation, then event in the clear cycle
        for (int i = 0; i < 16; i++) pulse(8'h55, 8'(i));
        for (int i = 0; i < 260; i++) pulse(8'h66, 8'(i));
        chk("sat.drop_cnt", 32'(drop_cnt), 32'd255);
        tick(1'b1, 8'h77, 8'h77, 1'b0, 1'b1);
        chk("setwins.drop_cnt", 32'(drop_cnt), 32'd1);
        chk("setwins.overflow", 32'(overflow), 32'd1);
        tick(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) tick(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);

        // 5: underflow, push with rd_en while empty, interleaved wrap
        tick(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        chk("uflow.underflow", 32'(underflow), 32'd1);
        chk("uflow.count",     32'(count),     32'd0);
        tick(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        tick(1'b1, 8'hC0, 8'h00, 1'b1, 1'b0);
        chk("emptypush.count",     32'(count),     32'd1);
        chk("emptypush.underflow", 32'(underflow), 32'd1);
        for (int i = 1; i <= 40; i++) begin
            tick(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
            tick(1'b1, 8'hC0, 8'(i), 1'b1, 1'b0);
            chk("wrap.count_le1", 32'(count <= 5'd1), 32'd1);
            chk("wrap.head", 32'(rd_data), 32'({8'hC0, 8'(i)}));
        end
        tick(1'b0, 8'h00, 8'h00, 1'b1, 1'b1);

        // 6: asynchronous reset mid-fill
        for (int i = 0; i < 7; i++) pulse(8'hD0, 8'(i));
        chk("prereset.count", 32'(count), 32'd7);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async.count",    32'(count),    32'd0);
        chk("async.rd_valid", 32'(rd_valid), 32'd0);
        chk("async.rd_data",  32'(rd_data),  32'h0);
        model_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        tick(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        pulse(8'hE1, 8'hE2);
        chk("postreset.head", 32'(rd_data), 32'hE1E2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
